// File: rtl/lift_seq_ctrl.sv
// Control sequencer for the q->p lift datapath: walks a whole polynomial of residues, emits
// delayed per-coefficient stage starts and tracks the result write slot until the last result.
module lift_seq_ctrl #(
   parameter int N_IN_M0  = 6,
   parameter int N_IN_M1  = 7,
   parameter int N_OUT_M0 = 7,
   parameter int N_OUT_M1 = 6,
   parameter int AW       = 3,
   parameter int CW       = 12,
   parameter int N_COEFF  = 4096,
   parameter int LAT_FIX  = 9,
   parameter int LAT_QUO  = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic [CW-1:0] rd_coeff,
   output logic          start_fixedpt,
   output logic          start_quo,
   input  logic          result_we,
   output logic [AW-1:0] wr_addr,
   output logic [CW-1:0] wr_coeff,
   output logic          busy,
   output logic          done,
   output logic          err_start,
   output logic          err_we,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [CW-1:0] LAST_COEFF  = CW'(N_COEFF - 1);
   localparam logic [AW-1:0] LAST_IN_M0  = AW'(N_IN_M0 - 1);
   localparam logic [AW-1:0] LAST_IN_M1  = AW'(N_IN_M1 - 1);
   localparam logic [AW-1:0] LAST_OUT_M0 = AW'(N_OUT_M0 - 1);
   localparam logic [AW-1:0] LAST_OUT_M1 = AW'(N_OUT_M1 - 1);

   state_e               state_q, state_d;
   logic                 mode_q, mode_d;
   logic                 rd_en_q, rd_en_d;
   logic [AW-1:0]        rd_addr_q, rd_addr_d;
   logic [CW-1:0]        rd_coeff_q, rd_coeff_d;
   logic [AW-1:0]        wr_addr_q, wr_addr_d;
   logic [CW-1:0]        wr_coeff_q, wr_coeff_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_start_q, err_start_d;
   logic                 err_we_q, err_we_d;
   logic [LAT_FIX-1:0]   fix_sr_q, fix_sr_d;
   logic [LAT_QUO-1:0]   quo_sr_q, quo_sr_d;

   logic                 cstart;
   logic [AW-1:0]        last_in;
   logic [AW-1:0]        last_out;

   // A coefficient starts on the read of its residue 0.
   assign cstart   = rd_en_q & (rd_addr_q == '0);
   assign last_in  = mode_q ? LAST_IN_M1 : LAST_IN_M0;
   assign last_out = mode_q ? LAST_OUT_M1 : LAST_OUT_M0;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      rd_en_d     = rd_en_q;
      rd_addr_d   = rd_addr_q;
      rd_coeff_d  = rd_coeff_q;
      wr_addr_d   = wr_addr_q;
      wr_coeff_d  = wr_coeff_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_start_d = start & (state_q != IDLE);
      err_we_d    = result_we & (state_q == IDLE);
      // Delay lines run in every state so pulses launched before DRAIN still come out.
      fix_sr_d    = {fix_sr_q[LAT_FIX-2:0], cstart};
      quo_sr_d    = {quo_sr_q[LAT_QUO-2:0], cstart};

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = READ;
               mode_d     = mode;
               rd_en_d    = 1'b1;
               rd_addr_d  = '0;
               rd_coeff_d = '0;
               wr_addr_d  = '0;
               wr_coeff_d = '0;
               busy_d     = 1'b1;
            end
         end
         READ: begin
            if (rd_addr_q == last_in) begin
               if (rd_coeff_q == LAST_COEFF) begin
                  state_d = DRAIN;
                  rd_en_d = 1'b0;
               end else begin
                  rd_addr_d  = '0;
                  rd_coeff_d = rd_coeff_q + CW'(1);
               end
            end else begin
               rd_addr_d = rd_addr_q + AW'(1);
            end
         end
         DRAIN: begin
            rd_en_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The write side overrides the read side: the final result always closes the run.
      if ((state_q != IDLE) && result_we) begin
         if (wr_addr_q == last_out) begin
            wr_addr_d = '0;
            if (wr_coeff_q == LAST_COEFF) begin
               state_d    = IDLE;
               wr_coeff_d = '0;
               rd_en_d    = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
            end else begin
               wr_coeff_d = wr_coeff_q + CW'(1);
            end
         end else begin
            wr_addr_d = wr_addr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         rd_coeff_q  <= '0;
         wr_addr_q   <= '0;
         wr_coeff_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_start_q <= 1'b0;
         err_we_q    <= 1'b0;
         fix_sr_q    <= '0;
         quo_sr_q    <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         rd_coeff_q  <= rd_coeff_d;
         wr_addr_q   <= wr_addr_d;
         wr_coeff_q  <= wr_coeff_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_start_q <= err_start_d;
         err_we_q    <= err_we_d;
         fix_sr_q    <= fix_sr_d;
         quo_sr_q    <= quo_sr_d;
      end
   end

   assign rd_en         = rd_en_q;
   assign rd_addr       = rd_addr_q;
   assign rd_coeff      = rd_coeff_q;
   assign start_fixedpt = fix_sr_q[LAT_FIX-1];
   assign start_quo     = quo_sr_q[LAT_QUO-1];
   assign wr_addr       = wr_addr_q;
   assign wr_coeff      = wr_coeff_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_start     = err_start_q;
   assign err_we        = err_we_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_lift_seq_ctrl.sv
// Directed bench for lift_seq_ctrl with N_COEFF=4: expected read slots, stage-start cycles and
// write slots are queued when stimulus is driven and consumed by a negedge monitor.
module tb_lift_seq_ctrl;

   localparam int AW = 3;
   localparam int CW = 12;

   logic          clk;
   logic          rst;
   logic          start;
   logic          mode;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] rd_coeff;
   logic          start_fixedpt;
   logic          start_quo;
   logic          result_we;
   logic [AW-1:0] wr_addr;
   logic [CW-1:0] wr_coeff;
   logic          busy;
   logic          done;
   logic          err_start;
   logic          err_we;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [31:0] rd_exp_q[$];
   logic [31:0] fix_exp_q[$];
   logic [31:0] quo_exp_q[$];
   logic [31:0] wr_exp_q[$];

   lift_seq_ctrl #(
      .N_COEFF (4),
      .LAT_FIX (9),
      .LAT_QUO (24)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .mode          (mode),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_coeff      (rd_coeff),
      .start_fixedpt (start_fixedpt),
      .start_quo     (start_quo),
      .result_we     (result_we),
      .wr_addr       (wr_addr),
      .wr_coeff      (wr_coeff),
      .busy          (busy),
      .done          (done),
      .err_start     (err_start),
      .err_we        (err_we),
      .dbg_state     (dbg_state)
   );

   // Clock and cycle counter; inputs change 1 time unit after the rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   // Expected reads and stage-start cycles for a run whose start is sampled at the end of cycle t.
   task automatic push_run(input int t, input logic m);
      int n_in;
      int idx;
      n_in = m ? 7 : 6;
      idx  = 0;
      for (int c = 0; c < 4; c++) begin
         fix_exp_q.push_back(32'(t + 10 + n_in * c));
         quo_exp_q.push_back(32'(t + 25 + n_in * c));
         for (int a = 0; a < n_in; a++) begin
            rd_exp_q.push_back({17'(t + 1 + idx), 12'(c), 3'(a)});
            idx++;
         end
      end
   endtask

   task automatic start_run(input logic m);
      start = 1'b1;
      mode  = m;
      push_run(cyc, m);
      tick();
      start = 1'b0;
   endtask

   // Feed n_total results with random gaps; returns in the cycle where done must be high.
   task automatic feed_results(input int n_out, input int n_total, input logic toggle);
      for (int k = 0; k < n_total; k++) begin
         repeat ($urandom_range(0, 2)) begin
            if (toggle) mode = ~mode;
            tick();
         end
         result_we = 1'b1;
         wr_exp_q.push_back({17'd0, 12'(k / n_out), 3'(k % n_out)});
         if (k == n_total - 1) begin
            check("busy_last_we", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
         end
         if (toggle) mode = ~mode;
         tick();
         result_we = 1'b0;
      end
      check("done_pulse", 32'(done), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      check("wr_addr_at_done", 32'(wr_addr), 32'd0);
      check("wr_coeff_at_done", 32'(wr_coeff), 32'd0);
      check("state_at_done", 32'(dbg_state), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      check({tag, "_rd_coeff"}, 32'(rd_coeff), 32'd0);
      check({tag, "_fixedpt"}, 32'(start_fixedpt), 32'd0);
      check({tag, "_quo"}, 32'(start_quo), 32'd0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      check({tag, "_wr_coeff"}, 32'(wr_coeff), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_err_start"}, 32'(err_start), 32'd0);
      check({tag, "_err_we"}, 32'(err_we), 32'd0);
      check({tag, "_state"}, 32'(dbg_state), 32'd0);
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from input changes.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rd_en) begin
         if (rd_exp_q.size() == 0) check("rd_extra", 32'(rd_en), 32'd0);
         else begin
            e = rd_exp_q.pop_front();
            check("rd_slot", {17'(cyc), rd_coeff, rd_addr}, e);
         end
      end
      if (start_fixedpt) begin
         if (fix_exp_q.size() == 0) check("fix_extra", 32'(start_fixedpt), 32'd0);
         else begin
            e = fix_exp_q.pop_front();
            check("fix_cycle", 32'(cyc), e);
         end
      end
      if (start_quo) begin
         if (quo_exp_q.size() == 0) check("quo_extra", 32'(start_quo), 32'd0);
         else begin
            e = quo_exp_q.pop_front();
            check("quo_cycle", 32'(cyc), e);
         end
      end
      if (result_we && busy) begin
         if (wr_exp_q.size() == 0) check("wr_extra", 32'(result_we), 32'd0);
         else begin
            e = wr_exp_q.pop_front();
            check("wr_slot", {17'd0, wr_coeff, wr_addr}, e);
         end
      end
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      mode      = 1'b0;
      result_we = 1'b0;
      wait_cycles(3);
      check_all_zero("reset");
      rst = 1'b0;
      wait_cycles(2);

      // Mode 0 run; results fed after reads with mode toggled throughout.
      start_run(1'b0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_rd_en", 32'(rd_en), 32'd1);
      check("t1_state_read", 32'(dbg_state), 32'd1);
      wait_cycles(24);
      check("t1_state_drain", 32'(dbg_state), 32'd2);
      check("t1_rd_en_off", 32'(rd_en), 32'd0);
      check("t1_rd_addr_hold", 32'(rd_addr), 32'd5);
      check("t1_rd_coeff_hold", 32'(rd_coeff), 32'd3);
      feed_results(7, 28, 1'b1);
      mode = 1'b0;
      tick();
      check("t1_done_clear", 32'(done), 32'd0);
      wait_cycles(30);

      // Mode 1 run with results overlapping the read phase.
      start_run(1'b1);
      wait_cycles(7);
      feed_results(6, 24, 1'b0);
      wait_cycles(40);

      // Start while busy is flagged and ignored; result_we while idle likewise.
      start_run(1'b0);
      wait_cycles(4);
      start = 1'b1;
      mode  = 1'b1;
      tick();
      start = 1'b0;
      check("t4_err_start", 32'(err_start), 32'd1);
      check("t4_busy", 32'(busy), 32'd1);
      tick();
      check("t4_err_start_clr", 32'(err_start), 32'd0);
      wait_cycles(25);
      feed_results(7, 28, 1'b0);
      wait_cycles(3);
      result_we = 1'b1;
      tick();
      result_we = 1'b0;
      check("t4_err_we", 32'(err_we), 32'd1);
      check("t4_wr_addr_idle", 32'(wr_addr), 32'd0);
      check("t4_busy_idle", 32'(busy), 32'd0);
      tick();
      check("t4_err_we_clr", 32'(err_we), 32'd0);
      wait_cycles(30);

      // Reset mid-READ clears outputs and all pending stage pulses.
      start_run(1'b1);
      wait_cycles(11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd_exp_q.delete();
      fix_exp_q.delete();
      quo_exp_q.delete();
      wr_exp_q.delete();
      check_all_zero("midrst");
      wait_cycles(40);
      check("t5_state", 32'(dbg_state), 32'd0);

      // Start accepted in the done cycle of the previous run.
      start_run(1'b0);
      wait_cycles(26);
      feed_results(7, 28, 1'b0);
      start_run(1'b1);
      check("t6_busy", 32'(busy), 32'd1);
      check("t6_rd_en", 32'(rd_en), 32'd1);
      check("t6_rd_addr", 32'(rd_addr), 32'd0);
      check("t6_rd_coeff", 32'(rd_coeff), 32'd0);
      check("t6_done_clr", 32'(done), 32'd0);
      check("t6_err_start", 32'(err_start), 32'd0);
      wait_cycles(30);
      feed_results(6, 24, 1'b0);
      wait_cycles(50);

      check("rd_q_left", 32'(rd_exp_q.size()), 32'd0);
      check("fix_q_left", 32'(fix_exp_q.size()), 32'd0);
      check("quo_q_left", 32'(quo_exp_q.size()), 32'd0);
      check("wr_q_left", 32'(wr_exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
